// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one single-port memory between the OTTER
// instruction-fetch port (read-only) and the data-memory port (read/write).
// Round-robin arbitration, a single outstanding transaction, a ready/valid
// handshake towards memory and a grant-to-response timeout that reports an
// error to whichever requester owns the transaction.
module otter_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RST,

    // instruction-fetch port (read-only)
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    // data-memory port
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_err,

    // unified memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W     = DATA_W / 8;
    // counter only needs to reach TIMEOUT-1; the hit is flagged in that cycle
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam bit          TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;
    owner_t     last;
    mem_cmd_t   cmd;
    mem_cmd_t   cmd_sel;
    logic [CNT_W-1:0] cnt;

    logic       grant_if;
    logic       grant_dm;
    logic       grant;
    logic       busy;
    logic       resp;
    logic       timeout_hit;

    assign busy  = (state == REQ) || (state == WAIT);
    assign grant = grant_if || grant_dm;

    // response is only accepted while waiting for it; anything else is noise
    assign resp = (state == WAIT) && mem_rvalid && !RST;

    // a real response in the same cycle wins over the timeout
    assign timeout_hit = TO_EN && busy && !RST && !resp &&
                         (cnt == CNT_W'(CNT_LAST));

    // round-robin pick in IDLE: a lone requester wins, a tie goes to the one
    // that did not own the previous transaction
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if ((state == IDLE) && !RST) begin
            if (if_req && dm_req) begin
                if (last == OWN_DM) begin
                    grant_if = 1'b1;
                end else begin
                    grant_dm = 1'b1;
                end
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    // command captured at grant; fetches are always full-word reads
    always_comb begin
        cmd_sel = '0;
        if (grant_dm) begin
            cmd_sel.we    = dm_we;
            cmd_sel.addr  = dm_addr;
            cmd_sel.wdata = dm_wdata;
            cmd_sel.be    = dm_be;
        end else begin
            cmd_sel.we    = 1'b0;
            cmd_sel.addr  = if_addr;
            cmd_sel.wdata = '0;
            cmd_sel.be    = '1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (resp || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs: same-cycle grant, response pass-through and error pulse
    always_comb begin
        if_gnt    = grant_if;
        dm_gnt    = grant_dm;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        if_err    = 1'b0;
        dm_err    = 1'b0;
        if (resp) begin
            if (owner == OWN_DM) begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end else if (timeout_hit) begin
            if (owner == OWN_DM) begin
                dm_err = 1'b1;
            end else begin
                if_err = 1'b1;
            end
        end
    end

    // ownership, latched command, request strobe and timeout counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner   <= OWN_IF;
            last    <= OWN_DM;
            cmd     <= '0;
            mem_req <= 1'b0;
            cnt     <= '0;
        end else if (grant) begin
            owner   <= grant_dm ? OWN_DM : OWN_IF;
            last    <= grant_dm ? OWN_DM : OWN_IF;
            cmd     <= cmd_sel;
            mem_req <= 1'b1;
            cnt     <= '0;
        end else begin
            if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((state == REQ) && (mem_ready || timeout_hit)) begin
                mem_req <= 1'b0;
            end
        end
    end

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_be    = cmd.be;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: transaction-level reference
// model, per-cycle compare process, directed scenarios with literal
// expectations followed by randomized traffic.
module tb_otter_mem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int          TIMEOUT = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid, if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt, dm_rvalid, dm_err;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    otter_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit                m_busy   = 1'b0;
    bit                m_own_dm = 1'b0;
    bit                m_last_dm = 1'b1;
    bit                m_acc    = 1'b0;
    int                m_age    = 0;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;

    typedef struct packed {
        bit if_gnt;
        bit dm_gnt;
        bit resp;
        bit tout;
    } pred_t;

    function automatic pred_t predict();
        pred_t p;
        p = '0;
        if (!m_busy) begin
            p.if_gnt = if_req && (!dm_req || m_last_dm);
            p.dm_gnt = dm_req && (!if_req || !m_last_dm);
        end else begin
            p.resp = m_acc && mem_rvalid;
            p.tout = !p.resp && (TIMEOUT != 0) && (m_age >= TIMEOUT);
        end
        return p;
    endfunction

    // advance the model on each clock edge using the inputs the DUT sampled
    always @(posedge CLK) begin
        pred_t p;
        p = predict();
        if (RST) begin
            m_busy    = 1'b0;
            m_last_dm = 1'b1;
            m_acc     = 1'b0;
            m_age     = 0;
        end else if (!m_busy) begin
            if (p.if_gnt || p.dm_gnt) begin
                m_busy    = 1'b1;
                m_own_dm  = p.dm_gnt;
                m_last_dm = p.dm_gnt;
                m_acc     = 1'b0;
                m_age     = 1;
                if (p.dm_gnt) begin
                    m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
                end else begin
                    m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_be = '1;
                end
            end
        end else if (p.resp || p.tout) begin
            m_busy = 1'b0;
        end else begin
            if (!m_acc && mem_ready) m_acc = 1'b1;
            m_age++;
        end
    end

    // compare every non-reset cycle, mid low phase
    always @(negedge CLK) begin
        pred_t p;
        bit    exp_mreq;
        if (RST === 1'b0) begin
            p = predict();
            exp_mreq = m_busy && !m_acc;
            chk("if_gnt",    64'(if_gnt),    64'(p.if_gnt));
            chk("dm_gnt",    64'(dm_gnt),    64'(p.dm_gnt));
            chk("if_rvalid", 64'(if_rvalid), 64'(p.resp && !m_own_dm));
            chk("dm_rvalid", 64'(dm_rvalid), 64'(p.resp && m_own_dm));
            chk("if_rdata",  64'(if_rdata),  (p.resp && !m_own_dm) ? 64'(mem_rdata) : 64'd0);
            chk("dm_rdata",  64'(dm_rdata),  (p.resp && m_own_dm) ? 64'(mem_rdata) : 64'd0);
            chk("if_err",    64'(if_err),    64'(p.tout && !m_own_dm));
            chk("dm_err",    64'(dm_err),    64'(p.tout && m_own_dm));
            chk("mem_req",   64'(mem_req),   64'(exp_mreq));
            if (exp_mreq) begin
                chk("mem_we",   64'(mem_we),   64'(m_we));
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("mem_be",   64'(mem_be),   64'(m_be));
                if (m_own_dm) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] ord;
    int         ng;
    bit         silent;

    initial begin
        RST = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
        dm_wdata = '0; dm_be = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) cyc();
        RST = 1'b0;
        #2;
        chk("rst_if_gnt",   64'(if_gnt),    64'd0);
        chk("rst_mem_req",  64'(mem_req),   64'd0);
        chk("rst_mem_we",   64'(mem_we),    64'd0);
        chk("rst_mem_addr", 64'(mem_addr),  64'd0);
        chk("rst_mem_be",   64'(mem_be),    64'd0);
        chk("rst_if_rdata", 64'(if_rdata),  64'd0);
        chk("rst_dm_rvalid",64'(dm_rvalid), 64'd0);

        // 1: single fetch, minimum latency
        cyc(); if_req = 1; if_addr = 32'h0; mem_ready = 1; #2;
        chk("t1_if_gnt", 64'(if_gnt), 64'd1);
        cyc(); if_req = 0; #2;
        chk("t1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_mem_we",  64'(mem_we),  64'd0);
        chk("t1_mem_be",  64'(mem_be),  64'hF);
        cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0093; #2;
        chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("t1_if_rdata",  64'(if_rdata),  64'h93);
        chk("t1_dm_rvalid", 64'(dm_rvalid), 64'd0);
        cyc(); mem_rvalid = 0;

        // 2: write held off by memory for three cycles
        cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h0000_1000; dm_wdata = 32'hDEAD_BEEF;
        dm_be = 4'h3; mem_ready = 0; #2;
        chk("t2_dm_gnt", 64'(dm_gnt), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(); dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0; #2;
            chk("t2_mem_req",   64'(mem_req),   64'd1);
            chk("t2_mem_addr",  64'(mem_addr),  64'h1000);
            chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            chk("t2_mem_be",    64'(mem_be),    64'h3);
            chk("t2_mem_we",    64'(mem_we),    64'd1);
        end
        cyc(); mem_ready = 1; #2;
        chk("t2_mem_req_acc", 64'(mem_req), 64'd1);
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; #2;
        chk("t2_dm_rvalid", 64'(dm_rvalid), 64'd1);
        cyc(); mem_rvalid = 0;

        // 3: both requesting continuously -> strict alternation
        cyc(); if_req = 1; dm_req = 1; if_addr = 32'h40; dm_addr = 32'h80; mem_ready = 1; mem_rvalid = 1;
        ord = '0; ng = 0;
        for (int c = 0; c < 60 && ng < 8; c++) begin
            #2;
            if (if_gnt || dm_gnt) begin
                chk("t3_single_gnt", 64'(if_gnt & dm_gnt), 64'd0);
                ord[ng] = dm_gnt;
                ng++;
            end
            cyc();
        end
        chk("t3_grant_count", 64'(ng), 64'd8);
        chk("t3_grant_order", 64'(ord), 64'hAA);
        if_req = 0; dm_req = 0;
        repeat (3) cyc();
        mem_rvalid = 0;

        // 4: read that never gets a response -> timeout
        cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h2000; mem_ready = 1; mem_rvalid = 0; #2;
        chk("t4_dm_gnt", 64'(dm_gnt), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc(); dm_req = 0; if (k == 8) if_req = 1; #2;
            chk("t4_dm_err",    64'(dm_err),    64'(k == 8));
            chk("t4_dm_rvalid", 64'(dm_rvalid), 64'd0);
            if (k == 8) chk("t4_if_gnt_busy", 64'(if_gnt), 64'd0);
        end
        cyc(); #2;
        chk("t4_if_gnt_after", 64'(if_gnt), 64'd1);
        cyc(); if_req = 0;
        cyc(); mem_rvalid = 1;
        cyc(); mem_rvalid = 0;

        // 5: reset while waiting; late response must be dropped
        cyc(); if_req = 1; if_addr = 32'h100; mem_ready = 1;
        cyc(); if_req = 0;
        cyc(); RST = 1;
        cyc(); RST = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; #2;
        chk("t5_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("t5_dm_rvalid", 64'(dm_rvalid), 64'd0);
        chk("t5_if_rdata",  64'(if_rdata),  64'd0);
        chk("t5_mem_req",   64'(mem_req),   64'd0);
        chk("t5_mem_addr",  64'(mem_addr),  64'd0);
        chk("t5_mem_be",    64'(mem_be),    64'd0);
        cyc(); mem_rvalid = 0;

        // 6: spurious rvalid during REQ is ignored
        cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h3000; mem_ready = 0; #2;
        chk("t6_dm_gnt", 64'(dm_gnt), 64'd1);
        cyc(); dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD; #2;
        chk("t6_early_rvalid", 64'(dm_rvalid), 64'd0);
        cyc(); mem_rvalid = 0; mem_ready = 1; #2;
        chk("t6_acc_rvalid", 64'(dm_rvalid), 64'd0);
        cyc(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE; #2;
        chk("t6_dm_rvalid", 64'(dm_rvalid), 64'd1);
        chk("t6_dm_rdata",  64'(dm_rdata),  64'hCAFE);
        cyc(); #2;
        chk("t6_no_repeat", 64'(dm_rvalid), 64'd0);
        cyc(); mem_rvalid = 0;

        // randomized traffic against the model
        silent = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (c % 64 == 0) silent = ($urandom_range(0, 3) == 0);
            RST        = ($urandom_range(0, 299) == 0);
            if_req     = ($urandom_range(0, 2) != 0);
            dm_req     = ($urandom_range(0, 2) != 0);
            if_addr    = $urandom;
            dm_we      = 1'($urandom_range(0, 1));
            dm_addr    = $urandom;
            dm_wdata   = $urandom;
            dm_be      = 4'($urandom);
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = silent ? 1'b0 : ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
        end
        cyc(); RST = 0; if_req = 0; dm_req = 0; mem_rvalid = 0;
        repeat (2) @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
